// File: rtl/hazard_pkg.sv
// Shared constants and types for the ID-stage hazard stall/flush controller.
package hazard_pkg;

    localparam int HZ_REG_W       = 4;
    localparam int HZ_MEM_TIMEOUT = 64;
    localparam int HZ_CNT_W       = 16;

    // Remaining-stall counter only ever needs to hold N-1 with N <= 2
    localparam int STALL_W = 2;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_ID_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    typedef struct packed {
        logic load_use;
        logic br_ex_alu;
        logic br_ex_load;
        logic br_mem_load;
    } hazard_flags_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one in-flight destination against the ID sources; r0 never matches
// and Rt only counts when the ID instruction actually reads it.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_W = HZ_REG_W
)(
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rt,
    output logic             hit
);

    logic rs_hit_s;
    logic rt_hit_s;

    assign rs_hit_s = (rd == rs) && (rs != {REG_W{1'b0}});
    assign rt_hit_s = (rd == rt) && (rt != {REG_W{1'b0}}) && uses_rt;
    assign hit      = rs_hit_s || rt_hit_s;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller beside the ID stage: load-use and branch-operand
// stalls, data-memory wait freeze, taken-branch squash and stall accounting.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W       = HZ_REG_W,
    parameter int MEM_TIMEOUT = HZ_MEM_TIMEOUT,
    parameter int CNT_W       = HZ_CNT_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IF_ID_Rs,
    input  logic [REG_W-1:0] IF_ID_Rt,
    input  logic             IF_ID_uses_Rt,
    input  logic             IF_ID_is_branch,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] ID_EX_Rd,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] EX_MEM_Rd,
    input  logic             EX_MEM_MemRead,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic             stall_all,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic               ex_hit_s;
    logic               mem_hit_s;
    hazard_flags_t      flags_s;
    logic [STALL_W-1:0] need_s;
    logic               mem_stall_s;

    logic [1:0]         state_r, state_nx_s;
    logic [1:0]         ret_state_r, ret_state_nx_s;
    logic [STALL_W-1:0] stall_left_r, stall_left_nx_s;
    logic [WAIT_W-1:0]  wait_cnt_r, wait_cnt_nx_s, wait_inc_s;
    logic               mem_timeout_r;
    logic [CNT_W-1:0]   stall_count_r;

    logic pc_write_s, if_id_write_s, bubble_s, flush_s, stall_all_s;

    hazard_match #(.REG_W(REG_W)) u_match_ex (
        .rd      (ID_EX_Rd),
        .rs      (IF_ID_Rs),
        .rt      (IF_ID_Rt),
        .uses_rt (IF_ID_uses_Rt),
        .hit     (ex_hit_s)
    );

    hazard_match #(.REG_W(REG_W)) u_match_mem (
        .rd      (EX_MEM_Rd),
        .rs      (IF_ID_Rs),
        .rt      (IF_ID_Rt),
        .uses_rt (IF_ID_uses_Rt),
        .hit     (mem_hit_s)
    );

    assign flags_s.load_use    = ID_EX_MemRead && ex_hit_s;
    assign flags_s.br_ex_alu   = IF_ID_is_branch && ID_EX_RegWrite && !ID_EX_MemRead && ex_hit_s;
    assign flags_s.br_ex_load  = IF_ID_is_branch && ID_EX_MemRead && ex_hit_s;
    assign flags_s.br_mem_load = IF_ID_is_branch && EX_MEM_MemRead && mem_hit_s;
    assign mem_stall_s         = dmem_req && !dmem_ready;
    assign wait_inc_s          = (wait_cnt_r == WAIT_MAX) ? WAIT_MAX : wait_cnt_r + WAIT_W'(1);

    // Required stall cycles: the largest demand among the active hazards
    always_comb begin
        if (flags_s.br_ex_load) begin
            need_s = 2'd2;
        end else if (flags_s.load_use || flags_s.br_ex_alu || flags_s.br_mem_load) begin
            need_s = 2'd1;
        end else begin
            need_s = 2'd0;
        end
    end

    // Next-state and output decode; memory wait outranks ID stalls, which outrank flush
    always_comb begin
        state_nx_s      = state_r;
        ret_state_nx_s  = ret_state_r;
        stall_left_nx_s = stall_left_r;
        wait_cnt_nx_s   = wait_cnt_r;
        pc_write_s      = 1'b1;
        if_id_write_s   = 1'b1;
        bubble_s        = 1'b0;
        flush_s         = 1'b0;
        stall_all_s     = 1'b0;
        case (state_r)
            ST_RUN, ST_ID_STALL: begin
                if (mem_stall_s) begin
                    // Freeze; the pending ID stall (if any) resumes after the access
                    stall_all_s    = 1'b1;
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    state_nx_s     = ST_MEM_WAIT;
                    ret_state_nx_s = state_r;
                    wait_cnt_nx_s  = WAIT_W'(1);
                end else if (state_r == ST_ID_STALL) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    bubble_s      = 1'b1;
                    if (stall_left_r <= 2'd1) begin
                        state_nx_s      = ST_RUN;
                        stall_left_nx_s = 2'd0;
                    end else begin
                        stall_left_nx_s = stall_left_r - 2'd1;
                    end
                end else if (need_s != 2'd0) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    bubble_s      = 1'b1;
                    if (need_s >= 2'd2) begin
                        state_nx_s      = ST_ID_STALL;
                        stall_left_nx_s = need_s - 2'd1;
                    end else begin
                        state_nx_s      = ST_RUN;
                    end
                end else begin
                    flush_s = IF_ID_is_branch && branch_taken;
                end
            end
            ST_MEM_WAIT: begin
                stall_all_s   = 1'b1;
                pc_write_s    = 1'b0;
                if_id_write_s = 1'b0;
                if (dmem_ready) begin
                    state_nx_s    = ret_state_r;
                    wait_cnt_nx_s = {WAIT_W{1'b0}};
                end else begin
                    wait_cnt_nx_s = wait_inc_s;
                end
            end
            default: begin
                state_nx_s      = ST_RUN;
                ret_state_nx_s  = ST_RUN;
                stall_left_nx_s = 2'd0;
                wait_cnt_nx_s   = {WAIT_W{1'b0}};
            end
        endcase
    end

    // FSM state, wait counter, sticky timeout and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            ret_state_r   <= ST_RUN;
            stall_left_r  <= 2'd0;
            wait_cnt_r    <= {WAIT_W{1'b0}};
            mem_timeout_r <= 1'b0;
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_nx_s;
            ret_state_r   <= ret_state_nx_s;
            stall_left_r  <= stall_left_nx_s;
            wait_cnt_r    <= wait_cnt_nx_s;
            mem_timeout_r <= mem_timeout_r || (wait_cnt_nx_s == WAIT_MAX);
            if (!pc_write_s && (stall_count_r != CNT_MAX)) begin
                stall_count_r <= stall_count_r + CNT_W'(1);
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    // Hold the control outputs at their idle values for as long as reset is asserted
    assign pc_write     = rst_n ? pc_write_s    : 1'b1;
    assign IF_ID_write  = rst_n ? if_id_write_s : 1'b1;
    assign ID_EX_bubble = rst_n ? bubble_s      : 1'b0;
    assign IF_ID_flush  = rst_n ? flush_s       : 1'b0;
    assign stall_all    = rst_n ? stall_all_s   : 1'b0;
    assign mem_timeout  = mem_timeout_r;
    assign stall_count  = stall_count_r;

endmodule
